vga_sprite_scheduler: RTL and testbench
=======================================

// Module: vga_sprite_scheduler
// PURPOSE
//  Drives the 12 colour inputs of the VGA timing generator. Each pixel goes to one
//  of N_SPR rectangular sprites or to a background colour; lowest index wins.
//  Software writes sprite position, colour and enable to shadow registers through a
//  valid/ready port. Shadow is copied to the active set once per frame, on the vsync
//  rising edge, so every frame is drawn from one set of values (no tearing).
// PARAMETERS
//  N_SPR   4    number of sprites (1..8)
//  SPR_W   64   sprite width, pixels
//  SPR_H   64   sprite height, lines
//  IDW     3    cfg_sel width; must satisfy 2**IDW > N_SPR
// PORTS
//  clk        in   1   pixel clock, same clock as the timing generator
//  rst_n      in   1   reset, synchronous, active-low
//  vsync      in   1   timing generator vsync (active-high during lines 0..2)
//  curr_x     in   11  active-area x, 0..1279
//  curr_y     in   10  active-area y, 0..799
//  cfg_valid  in   1   config write request
//  cfg_ready  out  1   config write accepted when valid & ready
//  cfg_sel    in   IDW target: 0..N_SPR-1 = sprite, N_SPR = background, others ignored
//  cfg_en     in   1   sprite enable (ignored when target is background)
//  cfg_x      in   11  sprite left x
//  cfg_y      in   10  sprite top y
//  cfg_rgb    in   12  colour {r[3:0],g[3:0],b[3:0]}
//  pix_rgb    out  12  registered colour to timing generator r3..r0, g3..g0, b3..b0
//  hit_valid  out  1   registered: a sprite covers the current pixel
//  hit_id     out  IDW registered: index of winning sprite (0 when !hit_valid)
//  frame_cnt  out  8   count of commits, wraps 255 -> 0
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//   - All shadow and active enables = 0; positions = 0; colours = 0.
//   - pix_rgb=0, hit_valid=0, hit_id=0, frame_cnt=0, cfg_ready=0.
//   - vsync edge register = 0. Reset mid-frame drops any pending shadow data.
//  cfg_ready = 1 in every cycle after reset, except the commit cycle.
//   - On a write (valid & ready), the shadow entry named by cfg_sel is updated at that edge.
//   - Unused fields are don't-care: cfg_en/x/y when target is background;
//     cfg_x/y/en are still stored for a sprite.
//   - Out-of-range cfg_sel (> N_SPR) is accepted and discarded.
//  Commit:
//   - Triggered when vsync_q=0 and vsync=1 (one cycle per frame).
//   - At that edge: active <= shadow for all entries; frame_cnt += 1; cfg_ready=0.
//   - A write pending in the commit cycle is not taken. It is accepted the next cycle
//     and lands in the following frame.
//   - Shadow holds its value after commit; only changed fields need rewriting.
//  Hit test for sprite i, combinational on active regs:
//   - en_i & curr_x >= x_i & curr_x < x_i+SPR_W & curr_y >= y_i & curr_y < y_i+SPR_H.
//   - Sums are computed 12-bit (x) and 11-bit (y) so they cannot wrap; sprites that
//     hang off the right or bottom edge clip naturally.
//   - Fixed priority encoder: lowest i with a hit wins.
//  Output: latency 1 clk from curr_x/curr_y to pix_rgb / hit_*.
//   - pix_rgb <= winner colour, else background colour.
//   - Blanking needs no special case: the timing generator zeroes blanking itself.
//  A commit and a pixel in the same cycle: the pixel uses the pre-commit active set.
// STRUCTURE
//  Shared package vga_pkg:
//   - H_ACTIVE=1280, V_ACTIVE=800
//   - RGB_W=12
//   - localparams for the r/g/b field slices of a 12-bit colour
//  Sub-module vga_sprite_hit (one per sprite, generate loop): pure combinational
//   rectangle compare; inputs en/x/y/curr_x/curr_y, output hit.
//  Top: shadow and active register arrays, vsync edge detector, priority encoder,
//   output registers.
// TESTING
//  T1 reset: rst_n=0 for 3 clk mid-frame -> all outputs 0; cfg_ready=1 on first clk
//     after release.
//  T2 commit timing: write bg=12'hF00, sprite0 en at (100,50), rgb 12'h0F0, before
//     vsync rise -> old colours until the edge; then at (100,50) pix_rgb=0F0, hit_id=0,
//     and at (99,50) pix_rgb=F00 one clk later; frame_cnt=1.
//  T3 priority: sprite0 (0,0) rgb 00F and sprite2 (32,32) rgb FFF, both enabled, SPR_W=64
//     -> (40,40) gives 00F, id 0; (80,80) gives FFF, id 2; (100,100) gives bg.
//  T4 collision: hold cfg_valid with sprite1 x=500 across the vsync rise
//     -> cfg_ready=0 that cycle; accepted next cycle; visible only after the second
//     commit.
//  T5 edges: sprite at (1250,780) -> hit at (1279,799), hit_valid=0 at (0,0); no wrap.
//     cfg_sel=7 with N_SPR=4 -> accepted, no state change.
//  T6 wrap: 256 vsync rises -> frame_cnt returns to 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants: active-area geometry, coordinate widths and colour field slices.
package vga_pkg;
  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 800;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;
  localparam int RGB_W    = 12;
  localparam int R_HI = 11, R_LO = 8;
  localparam int G_HI = 7,  G_LO = 4;
  localparam int B_HI = 3,  B_LO = 0;
endpackage

// File: rtl/vga_sprite_hit.sv
// Combinational rectangle test for one sprite against the current pixel.
module vga_sprite_hit
  import vga_pkg::*;
#(
  parameter int SPR_W = 64,
  parameter int SPR_H = 64
) (
  input  logic           en_i,
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  input  logic [X_W-1:0] curr_x_i,
  input  logic [Y_W-1:0] curr_y_i,
  output logic           hit_o
);
  // One extra bit so right/bottom ends never wrap; off-screen parts just clip.
  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;

  assign x_end = {1'b0, x_i} + (X_W+1)'(SPR_W);
  assign y_end = {1'b0, y_i} + (Y_W+1)'(SPR_H);

  assign hit_o = en_i
               & (curr_x_i >= x_i) & ({1'b0, curr_x_i} < x_end)
               & (curr_y_i >= y_i) & ({1'b0, curr_y_i} < y_end);
endmodule

// File: rtl/vga_sprite_scheduler.sv
// Sprite compositor: shadow config regs committed to the active set on vsync rise,
// per-sprite hit test, fixed-priority pick and a registered colour output.
module vga_sprite_scheduler
  import vga_pkg::*;
#(
  parameter int N_SPR = 4,
  parameter int SPR_W = 64,
  parameter int SPR_H = 64,
  parameter int IDW   = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             vsync_i,
  input  logic [X_W-1:0]   curr_x_i,
  input  logic [Y_W-1:0]   curr_y_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [IDW-1:0]   cfg_sel_i,
  input  logic             cfg_en_i,
  input  logic [X_W-1:0]   cfg_x_i,
  input  logic [Y_W-1:0]   cfg_y_i,
  input  logic [RGB_W-1:0] cfg_rgb_i,
  output logic [RGB_W-1:0] pix_rgb_o,
  output logic             hit_valid_o,
  output logic [IDW-1:0]   hit_id_o,
  output logic [7:0]       frame_cnt_o
);
  logic [N_SPR-1:0]             sh_en_q, act_en_q;
  logic [N_SPR-1:0][X_W-1:0]    sh_x_q, act_x_q;
  logic [N_SPR-1:0][Y_W-1:0]    sh_y_q, act_y_q;
  logic [N_SPR-1:0][RGB_W-1:0]  sh_rgb_q, act_rgb_q;
  logic [RGB_W-1:0]             sh_bg_q, act_bg_q;
  logic                         vsync_q, rdy_q;
  logic [7:0]                   frame_cnt_q;
  logic [RGB_W-1:0]             pix_q;
  logic                         hv_q;
  logic [IDW-1:0]               hid_q;

  logic             commit, wr;
  logic [N_SPR-1:0] hit;
  logic             win_hit_d;
  logic [IDW-1:0]   win_id_d;
  logic [RGB_W-1:0] win_rgb_d;

  assign commit      = ~vsync_q & vsync_i;
  assign cfg_ready_o = rdy_q & ~commit;
  assign wr          = cfg_valid_i & cfg_ready_o;

  for (genvar i = 0; i < N_SPR; i++) begin : g_hit
    vga_sprite_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .en_i     (act_en_q[i]),
      .x_i      (act_x_q[i]),
      .y_i      (act_y_q[i]),
      .curr_x_i (curr_x_i),
      .curr_y_i (curr_y_i),
      .hit_o    (hit[i])
    );
  end

  // Walk downwards so the lowest hitting index is the last (winning) assignment.
  always_comb begin
    win_hit_d = 1'b0;
    win_id_d  = '0;
    win_rgb_d = act_bg_q;
    for (int i = N_SPR-1; i >= 0; i--) begin
      if (hit[i]) begin
        win_hit_d = 1'b1;
        win_id_d  = IDW'(i);
        win_rgb_d = act_rgb_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sh_en_q <= '0; sh_x_q <= '0; sh_y_q <= '0; sh_rgb_q <= '0; sh_bg_q <= '0;
      act_en_q <= '0; act_x_q <= '0; act_y_q <= '0; act_rgb_q <= '0; act_bg_q <= '0;
      vsync_q <= 1'b0; rdy_q <= 1'b0; frame_cnt_q <= '0;
      pix_q <= '0; hv_q <= 1'b0; hid_q <= '0;
    end else begin
      vsync_q <= vsync_i;
      rdy_q   <= 1'b1;
      // Pixel path sees the pre-commit active set on a commit edge.
      pix_q   <= win_rgb_d;
      hv_q    <= win_hit_d;
      hid_q   <= win_id_d;
      if (commit) begin
        act_en_q    <= sh_en_q;
        act_x_q     <= sh_x_q;
        act_y_q     <= sh_y_q;
        act_rgb_q   <= sh_rgb_q;
        act_bg_q    <= sh_bg_q;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      for (int i = 0; i < N_SPR; i++) begin
        if (wr && cfg_sel_i == IDW'(i)) begin
          sh_en_q[i]  <= cfg_en_i;
          sh_x_q[i]   <= cfg_x_i;
          sh_y_q[i]   <= cfg_y_i;
          sh_rgb_q[i] <= cfg_rgb_i;
        end
      end
      if (wr && cfg_sel_i == IDW'(N_SPR)) sh_bg_q <= cfg_rgb_i;
    end
  end

  assign pix_rgb_o   = pix_q;
  assign hit_valid_o = hv_q;
  assign hit_id_o    = hid_q;
  assign frame_cnt_o = frame_cnt_q;
endmodule

// File: tb/tb_vga_sprite_scheduler.sv
// Randomized + directed bench for vga_sprite_scheduler against a frame-level reference model.
module tb_vga_sprite_scheduler;
  localparam int N = 4;
  localparam int SW = 64, SH = 64;

  logic        clk, rst_n, vsync;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic        cfg_valid, cfg_ready;
  logic [2:0]  cfg_sel;
  logic        cfg_en;
  logic [10:0] cfg_x;
  logic [9:0]  cfg_y;
  logic [11:0] cfg_rgb, pix_rgb;
  logic        hit_valid;
  logic [2:0]  hit_id;
  logic [7:0]  frame_cnt;

  vga_sprite_scheduler #(.N_SPR(N), .SPR_W(SW), .SPR_H(SH), .IDW(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .vsync_i(vsync),
    .curr_x_i(curr_x), .curr_y_i(curr_y),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_sel_i(cfg_sel),
    .cfg_en_i(cfg_en), .cfg_x_i(cfg_x), .cfg_y_i(cfg_y), .cfg_rgb_i(cfg_rgb),
    .pix_rgb_o(pix_rgb), .hit_valid_o(hit_valid), .hit_id_o(hit_id),
    .frame_cnt_o(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: shadow / displayed sprite tables, one frame's worth of state.
  bit          m_sh_en[N], m_act_en[N];
  int          m_sh_x[N], m_sh_y[N], m_act_x[N], m_act_y[N];
  logic [11:0] m_sh_rgb[N], m_act_rgb[N];
  logic [11:0] m_sh_bg, m_act_bg;
  bit          m_vs_q, m_rdy;
  int          m_fc;
  logic [11:0] m_pix;
  bit          m_hv;
  int          m_hid;
  logic        obs_rdy;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_sh_en[i] = 0; m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_rgb[i] = 0;
      m_act_en[i] = 0; m_act_x[i] = 0; m_act_y[i] = 0; m_act_rgb[i] = 0;
    end
    m_sh_bg = 0; m_act_bg = 0; m_vs_q = 0; m_rdy = 0; m_fc = 0;
    m_pix = 0; m_hv = 0; m_hid = 0;
  endtask

  // One clock: check ready, predict the pixel, advance model and DUT, compare.
  task automatic cyc();
    bit commit, acc, eh;
    int eid, cx, cy;
    logic [11:0] ep;
    #1;
    commit  = !m_vs_q && vsync;
    obs_rdy = cfg_ready;
    chk("ready", {31'd0, cfg_ready}, {31'd0, m_rdy && !commit});
    cx = int'(curr_x); cy = int'(curr_y);
    eh = 0; eid = 0; ep = m_act_bg;
    for (int i = 0; i < N; i++) begin
      if (m_act_en[i] && cx >= m_act_x[i] && cx < m_act_x[i] + SW &&
          cy >= m_act_y[i] && cy < m_act_y[i] + SH) begin
        eh = 1; eid = i; ep = m_act_rgb[i];
        break;
      end
    end
    acc = cfg_valid && m_rdy && !commit;
    @(posedge clk);
    if (!rst_n) m_reset();
    else begin
      m_pix = ep; m_hv = eh; m_hid = eid;
      if (commit) begin
        for (int i = 0; i < N; i++) begin
          m_act_en[i] = m_sh_en[i]; m_act_x[i] = m_sh_x[i];
          m_act_y[i] = m_sh_y[i];   m_act_rgb[i] = m_sh_rgb[i];
        end
        m_act_bg = m_sh_bg;
        m_fc = (m_fc + 1) % 256;
      end
      if (acc) begin
        if (int'(cfg_sel) < N) begin
          m_sh_en[cfg_sel] = cfg_en; m_sh_x[cfg_sel] = int'(cfg_x);
          m_sh_y[cfg_sel] = int'(cfg_y); m_sh_rgb[cfg_sel] = cfg_rgb;
        end else if (int'(cfg_sel) == N) m_sh_bg = cfg_rgb;
      end
      m_vs_q = vsync;
      m_rdy = 1;
    end
    #1;
    chk("pix", {20'd0, pix_rgb}, {20'd0, m_pix});
    chk("hv", {31'd0, hit_valid}, {31'd0, m_hv});
    chk("hid", {29'd0, hit_id}, m_hid);
    chk("fcnt", {24'd0, frame_cnt}, m_fc);
  endtask

  task automatic wr(input int sel, input bit en, input int x, input int y, input int rgb);
    cfg_valid = 1; cfg_sel = 3'(sel); cfg_en = en;
    cfg_x = 11'(x); cfg_y = 10'(y); cfg_rgb = 12'(rgb);
    cyc();
    cfg_valid = 0;
  endtask

  task automatic frame();
    vsync = 1; cyc();
    vsync = 0; cyc();
  endtask

  task automatic px(input int x, input int y);
    curr_x = 11'(x); curr_y = 10'(y);
    cyc();
  endtask

  initial begin
    m_reset();
    rst_n = 1; vsync = 0; curr_x = 0; curr_y = 0;
    cfg_valid = 0; cfg_sel = 0; cfg_en = 0; cfg_x = 0; cfg_y = 0; cfg_rgb = 0;
    m_rdy = 1; // reset state of DUT is unknown until the first reset edge
    @(posedge clk); #1;

    // T1 reset
    rst_n = 0;
    repeat (3) cyc();
    chk("t1_pix", {20'd0, pix_rgb}, 0);
    chk("t1_fc", {24'd0, frame_cnt}, 0);
    chk("t1_rdy", {31'd0, cfg_ready}, 0);
    rst_n = 1;
    cyc();
    chk("t1_rdy_rel", {31'd0, cfg_ready}, 1);

    // T2 commit timing
    wr(4, 0, 0, 0, 12'hF00);
    wr(0, 1, 100, 50, 12'h0F0);
    px(100, 50);
    chk("t2_pre", {20'd0, pix_rgb}, 0);
    vsync = 1; cyc();
    chk("t2_edge", {20'd0, pix_rgb}, 0);
    vsync = 0; cyc();
    chk("t2_post", {20'd0, pix_rgb}, 12'h0F0);
    chk("t2_hv", {31'd0, hit_valid}, 1);
    chk("t2_id", {29'd0, hit_id}, 0);
    px(99, 50);
    chk("t2_left", {20'd0, pix_rgb}, 12'hF00);
    chk("t2_fc", {24'd0, frame_cnt}, 1);

    // T3 priority
    wr(0, 1, 0, 0, 12'h00F);
    wr(1, 0, 0, 0, 0);
    wr(2, 1, 32, 32, 12'hFFF);
    wr(3, 0, 0, 0, 0);
    frame();
    px(40, 40);
    chk("t3_a_pix", {20'd0, pix_rgb}, 12'h00F);
    chk("t3_a_id", {29'd0, hit_id}, 0);
    px(80, 80);
    chk("t3_b_pix", {20'd0, pix_rgb}, 12'hFFF);
    chk("t3_b_id", {29'd0, hit_id}, 2);
    px(100, 100);
    chk("t3_c_pix", {20'd0, pix_rgb}, 12'hF00);
    chk("t3_c_hv", {31'd0, hit_valid}, 0);

    // T4 write colliding with commit
    cfg_valid = 1; cfg_sel = 1; cfg_en = 1; cfg_x = 500; cfg_y = 0; cfg_rgb = 12'h0AA;
    vsync = 1; cyc();
    chk("t4_rdy_commit", {31'd0, obs_rdy}, 0);
    cyc();
    chk("t4_rdy_next", {31'd0, obs_rdy}, 1);
    cfg_valid = 0; vsync = 0;
    px(500, 10);
    chk("t4_before", {20'd0, pix_rgb}, 12'hF00);
    frame();
    px(500, 10);
    chk("t4_after", {20'd0, pix_rgb}, 12'h0AA);
    chk("t4_id", {29'd0, hit_id}, 1);

    // T5 edges and out-of-range select
    wr(0, 0, 0, 0, 0); wr(1, 0, 0, 0, 0); wr(2, 0, 0, 0, 0);
    wr(3, 1, 1250, 780, 12'h123);
    frame();
    px(1279, 799);
    chk("t5_corner", {20'd0, pix_rgb}, 12'h123);
    chk("t5_id", {29'd0, hit_id}, 3);
    px(0, 0);
    chk("t5_origin_hv", {31'd0, hit_valid}, 0);
    px(1249, 799);
    chk("t5_left_hv", {31'd0, hit_valid}, 0);
    wr(7, 1, 0, 0, 12'hABC);
    chk("t5_sel7_rdy", {31'd0, obs_rdy}, 1);
    frame();
    px(0, 0);
    chk("t5_sel7_bg", {20'd0, pix_rgb}, 12'hF00);
    px(1279, 799);
    chk("t5_sel7_spr", {20'd0, pix_rgb}, 12'h123);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      vsync = ((c % 37) < 3);
      rst_n = ($urandom_range(0, 799) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_sel = 3'($urandom_range(0, 7));
      cfg_en = 1'($urandom_range(0, 3) != 0);
      cfg_x = 11'($urandom_range(0, 300));
      cfg_y = 10'($urandom_range(0, 300));
      cfg_rgb = 12'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        curr_x = 11'($urandom_range(0, 1279));
        curr_y = 10'($urandom_range(0, 799));
      end else begin
        curr_x = 11'($urandom_range(0, 370));
        curr_y = 10'($urandom_range(0, 370));
      end
      cyc();
    end
    cfg_valid = 0; rst_n = 1; vsync = 0;

    // T6 frame counter wrap
    rst_n = 0; cyc();
    rst_n = 1; cyc();
    for (int k = 0; k < 256; k++) begin
      frame();
      if (k == 254) chk("t6_255", {24'd0, frame_cnt}, 255);
    end
    chk("t6_wrap", {24'd0, frame_cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
